// File: rtl/rr_arbiter_n.sv
// ============================================================================
//  Module   : rr_arbiter_n
//  Summary  : N-way round-robin / fixed-priority arbiter with valid/ready
//             winner port and per-requester acknowledge pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_n #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1,
  parameter int FL   = 2,
  parameter int BL   = 1,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_OFFER = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              valid_q, valid_d;
  logic [N-1:0]      ack_q, ack_d;

  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   any_win;
  logic [ID_W-1:0]   up_win;
  logic              up_found;
  logic [ID_W-1:0]   winner;
  logic              xfer;

  // Lowest set bit at or above start wins; otherwise wrap to lowest set bit.
  always_comb begin
    start    = (MODE == 1) ? '0 : ptr_q;
    any_win  = '0;
    up_win   = '0;
    up_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_win = ID_W'(i);
      end
      if (req[i] && (ID_W'(i) >= start)) begin
        up_win   = ID_W'(i);
        up_found = 1'b1;
      end
    end
    winner = up_found ? up_win : any_win;
  end

  assign xfer = (state_q == S_OFFER) && valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    valid_d = valid_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d = winner;
          if (FL == 0) begin
            state_d = S_OFFER;
          end else begin
            state_d = S_DELAY;
            cnt_d   = 4'(FL);
          end
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // out_valid rises one cycle after entering OFFER
        valid_d = 1'b1;
        if (xfer) begin
          valid_d = 1'b0;
          for (int i = 0; i < N; i++) begin
            ack_d[i] = (ID_W'(i) == id_q);
          end
          if (MODE == 1) begin
            ptr_d = '0;
          end else if (id_q == ID_W'(N - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + 1'b1;
          end
          if (BL == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = 4'(BL);
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
// ============================================================================
//  Module   : tb_rr_arbiter_n
//  Summary  : Self-checking bench for rr_arbiter_n (three configurations).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_n;

  localparam int NI = 3;
  localparam int FLV [NI] = '{2, 2, 0};
  localparam int BLV [NI] = '{1, 1, 0};
  localparam int MDV [NI] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_s [NI];
  logic       rdy_s [NI];
  logic [3:0] ack_s [NI];
  logic       vld_s [NI];
  logic [1:0] id_s  [NI];

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(4), .FL(2), .BL(1), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .ack(ack_s[0]),
    .out_valid(vld_s[0]), .out_ready(rdy_s[0]), .out_id(id_s[0]));

  rr_arbiter_n #(.N(4), .FL(2), .BL(1), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .ack(ack_s[1]),
    .out_valid(vld_s[1]), .out_ready(rdy_s[1]), .out_id(id_s[1]));

  rr_arbiter_n #(.N(4), .FL(0), .BL(0), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .req(req_s[2]), .ack(ack_s[2]),
    .out_valid(vld_s[2]), .out_ready(rdy_s[2]), .out_id(id_s[2]));

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;
  int cyc      = 0;

  // Transaction-timed model: each round is a sample edge, an offer window
  // opening FL+1 edges later, and a next-sample edge BL+1 edges after transfer.
  bit         m_busy  [NI];
  int         m_vfrom [NI];
  int         m_nsamp [NI];
  int         m_ptr   [NI];
  int         m_win   [NI];
  logic       m_valid [NI];
  logic [3:0] m_ack   [NI];
  logic [1:0] m_id    [NI];

  function automatic int pick(input logic [3:0] r, input int first);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (first + k) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  initial begin
    for (int m = 0; m < NI; m++) begin
      m_busy[m] = 1'b0; m_vfrom[m] = 0; m_nsamp[m] = 0; m_ptr[m] = 0;
      m_win[m] = 0; m_valid[m] = 1'b0; m_ack[m] = '0; m_id[m] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int m = 0; m < NI; m++) begin
        if (reset) begin
          m_busy[m] = 1'b0; m_ptr[m] = 0; m_valid[m] = 1'b0;
          m_ack[m] = '0; m_id[m] = '0; m_nsamp[m] = cyc + 1;
        end else begin
          m_ack[m] = '0;
          if (m_busy[m] && m_valid[m] && rdy_s[m]) begin
            m_ack[m]  = 4'(1 << m_win[m]);
            m_busy[m] = 1'b0;
            if (MDV[m] == 0) m_ptr[m] = (m_win[m] + 1) % 4;
            m_nsamp[m] = cyc + 1 + BLV[m];
          end else if (!m_busy[m] && cyc >= m_nsamp[m] && req_s[m] != 0) begin
            m_win[m]   = pick(req_s[m], (MDV[m] == 1) ? 0 : m_ptr[m]);
            m_id[m]    = 2'(m_win[m]);
            m_busy[m]  = 1'b1;
            m_vfrom[m] = cyc + 1 + FLV[m];
          end
          m_valid[m] = m_busy[m] && (cyc >= m_vfrom[m]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int m = 0; m < NI; m++) begin
          chk("model_valid", m, 32'(vld_s[m]), 32'(m_valid[m]));
          chk("model_id",    m, 32'(id_s[m]),  32'(m_id[m]));
          chk("model_ack",   m, 32'(ack_s[m]), 32'(m_ack[m]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the next ack pulse, checks it, then moves past it.
  task automatic grant(input int m, input logic [3:0] exp, input string nm,
                       output int at);
    int w;
    w = 0;
    while (ack_s[m] == 4'd0 && w < 40) begin
      step(1);
      w++;
    end
    chk(nm, m, 32'(ack_s[m]), 32'(exp));
    at = cyc;
    step(1);
  endtask

  int at_prev, at_now;
  int w;
  logic [3:0] seq2 [6];

  initial begin
    reset = 1'b1;
    for (int m = 0; m < NI; m++) begin
      req_s[m] = '0;
      rdy_s[m] = 1'b0;
    end
    step(2);
    started = 1'b1;
    chk("reset_valid", 0, 32'(vld_s[0]), 32'd0);
    chk("reset_ack",   0, 32'(ack_s[0]), 32'd0);
    chk("reset_id",    0, 32'(id_s[0]),  32'd0);

    // Single request, FL=2: offer appears three edges after the sample edge.
    reset    = 1'b0;
    req_s[0] = 4'b0100;
    rdy_s[0] = 1'b1;
    step(3);
    chk("t1_not_yet", 0, 32'(vld_s[0]), 32'd0);
    step(1);
    chk("t1_valid", 0, 32'(vld_s[0]), 32'd1);
    chk("t1_id",    0, 32'(id_s[0]),  32'd2);
    chk("t1_noack", 0, 32'(ack_s[0]), 32'd0);
    req_s[0] = 4'b0000;
    step(1);
    chk("t1_ack",      0, 32'(ack_s[0]), 32'b0100);
    chk("t1_drop",     0, 32'(vld_s[0]), 32'd0);
    step(1);
    chk("t1_ack_once", 0, 32'(ack_s[0]), 32'd0);

    // Pointer is 3: requests on 1 and 3 alternate, wrapping through 0.
    req_s[0] = 4'b1010;
    grant(0, 4'b1000, "t3_g0", at_now);
    grant(0, 4'b0010, "t3_g1", at_now);
    grant(0, 4'b1000, "t3_g2", at_now);

    // All requesting: strict rotation with a 6-cycle period.
    req_s[0] = 4'b1111;
    seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    at_prev = 0;
    for (int k = 0; k < 6; k++) begin
      grant(0, seq2[k], "t2_rot", at_now);
      if (k > 0) chk("t2_period", 0, 32'(at_now - at_prev), 32'd6);
      at_prev = at_now;
    end
    req_s[0] = 4'b0000;

    // Fixed priority: index 0 keeps winning until it withdraws.
    req_s[1] = 4'b1111;
    rdy_s[1] = 1'b1;
    for (int k = 0; k < 3; k++) grant(1, 4'b0001, "t4_fixed", at_now);
    req_s[1] = 4'b1110;
    grant(1, 4'b0010, "t4_next", at_now);
    req_s[1] = 4'b0000;

    // Backpressure: offer of id 1 must hold while req churns.
    req_s[0] = 4'b0010;
    rdy_s[0] = 1'b0;
    w = 0;
    while (!vld_s[0] && w < 20) begin
      step(1);
      w++;
    end
    chk("t5_valid", 0, 32'(vld_s[0]), 32'd1);
    chk("t5_id",    0, 32'(id_s[0]),  32'd1);
    for (int k = 0; k < 5; k++) begin
      req_s[0] = 4'($urandom);
      step(1);
      chk("t5_hold_valid", 0, 32'(vld_s[0]), 32'd1);
      chk("t5_hold_id",    0, 32'(id_s[0]),  32'd1);
      chk("t5_hold_noack", 0, 32'(ack_s[0]), 32'd0);
    end
    req_s[0] = 4'b0000;
    rdy_s[0] = 1'b1;
    step(1);
    chk("t5_ack", 0, 32'(ack_s[0]), 32'b0010);
    step(1);
    chk("t5_ack_once", 0, 32'(ack_s[0]), 32'd0);
    step(2);

    // Reset while the round for winner 3 is in DELAY.
    req_s[0] = 4'b1000;
    step(1);
    reset    = 1'b1;
    req_s[0] = 4'b0000;
    step(1);
    reset = 1'b0;
    chk("t6_valid", 0, 32'(vld_s[0]), 32'd0);
    chk("t6_ack",   0, 32'(ack_s[0]), 32'd0);
    req_s[0] = 4'b1111;
    grant(0, 4'b0001, "t6_restart", at_now);
    req_s[0] = 4'b0000;

    // FL=0, BL=0 instance: offer one edge after the sample edge.
    rdy_s[2] = 1'b1;
    req_s[2] = 4'b0100;
    step(1);
    chk("fl0_not_yet", 2, 32'(vld_s[2]), 32'd0);
    req_s[2] = 4'b0000;
    step(1);
    chk("fl0_valid", 2, 32'(vld_s[2]), 32'd1);
    chk("fl0_id",    2, 32'(id_s[2]),  32'd2);
    step(1);
    chk("fl0_ack",   2, 32'(ack_s[2]), 32'b0100);
    step(2);

    // Random traffic, checked every cycle against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int m = 0; m < NI; m++) begin
        req_s[m] = 4'($urandom);
        rdy_s[m] = ($urandom_range(3) != 0);
      end
      reset = ($urandom_range(149) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
